// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: sequencer state encoding
// and the register index that never carries a real dependency.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    HALTED    = 3'd4
  } seq_state_t;

  // Register $zero: writes to it are discarded, so it never creates a hazard.
  localparam int NOP_REG = 0;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load in EX is about to write. Purely combinational.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_ex_mem_read,
  output logic             o_lu
);

  logic w_dst_live;
  logic w_src_match;

  assign w_dst_live  = (i_ex_rt != REG_W'(NOP_REG));
  assign w_src_match = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
  assign o_lu        = i_ex_mem_read && w_dst_live && w_src_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: derives per-stage enables and flush/bubble
// controls from the debug run mode, load-use hazards and taken control flow,
// freezes fetch after a decoded HALT and counts advanced cycles.
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dbg_start,
  input  logic             dbg_step_mode,
  input  logic             dbg_step,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             id_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_clk_en,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             r_fetch_block;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             w_advance;
  logic             w_lu;
  logic             w_ctrl_xfer;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_ex_rt       (ex_rt),
    .i_ex_mem_read (ex_mem_read),
    .o_lu          (w_lu)
  );

  assign w_ctrl_xfer = id_branch_taken || id_jump;

  // State register, sticky fetch block and advanced-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_fetch_block <= 1'b0;
      r_cycle_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (id_halt && w_advance && !w_lu)
        r_fetch_block <= 1'b1;
      if (w_advance)
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  // Next-state logic; retiring HALT beats every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (dbg_start)
          w_state_nxt = dbg_step_mode ? STEP_WAIT : RUN;
      end
      RUN: begin
        w_advance = 1'b1;
        if (wb_halt)
          w_state_nxt = HALTED;
      end
      STEP_WAIT: begin
        if (dbg_step)
          w_state_nxt = STEP_EXEC;
      end
      STEP_EXEC: begin
        w_advance   = 1'b1;
        w_state_nxt = wb_halt ? HALTED : STEP_WAIT;
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Stage controls. Stall/flush are gated by advance because ID/EX gives them
  // priority over its load enable; a load-use stall outranks both the
  // branch flush and the HALT fetch block for the IF-side enables.
  always_comb begin
    id_ex_clk_en = w_advance;
    ex_mem_en    = w_advance;
    mem_wb_en    = w_advance;
    id_ex_stall  = w_advance && w_lu;
    id_ex_flush  = 1'b0;
    pc_en        = w_advance && !w_lu && !r_fetch_block;
    if_id_en     = w_advance && !w_lu;
    if_id_flush  = w_advance && !w_lu && (w_ctrl_xfer || r_fetch_block);
  end

  assign running   = (r_state == RUN) || (r_state == STEP_WAIT) ||
                     (r_state == STEP_EXEC);
  assign halted    = (r_state == HALTED);
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run compared against a behavioural model of the run modes.
module tb_pipeline_sequencer;

  localparam int CNT_W = 32;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             dbg_start, dbg_step_mode, dbg_step;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             ex_mem_read, id_branch_taken, id_jump, id_halt, wb_halt;
  logic             pc_en, if_id_en, if_id_flush, id_ex_clk_en, id_ex_stall;
  logic             id_ex_flush, ex_mem_en, mem_wb_en, running, halted;
  logic [CNT_W-1:0] cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .dbg_start       (dbg_start),
    .dbg_step_mode   (dbg_step_mode),
    .dbg_step        (dbg_step),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_rt           (ex_rt),
    .ex_mem_read     (ex_mem_read),
    .id_branch_taken (id_branch_taken),
    .id_jump         (id_jump),
    .id_halt         (id_halt),
    .wb_halt         (wb_halt),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_clk_en    (id_ex_clk_en),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .running         (running),
    .halted          (halted),
    .cycle_cnt       (cycle_cnt)
  );

  // Packed view of the single-bit outputs, MSB first:
  // pc_en if_id_en if_id_flush id_ex_clk_en id_ex_stall id_ex_flush
  // ex_mem_en mem_wb_en running halted
  wire [9:0] outs = {pc_en, if_id_en, if_id_flush, id_ex_clk_en, id_ex_stall,
                     id_ex_flush, ex_mem_en, mem_wb_en, running, halted};

  task automatic clear_inputs();
    dbg_start = 0; dbg_step_mode = 0; dbg_step = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0;
    id_branch_taken = 0; id_jump = 0; id_halt = 0; wb_halt = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 0;
    #3;
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic start(input logic step_mode);
    dbg_step_mode = step_mode;
    dbg_start = 1;
    tick();
    dbg_start = 0;
    dbg_step_mode = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #3;
    n_checks++;
    if (outs !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_outs got %b want %b", outs, 10'b0);
    end
    n_checks++;
    if (cycle_cnt !== '0) begin
      n_errors++;
      $display("FAIL reset_cnt got %0d want 0", cycle_cnt);
    end
    @(negedge clk);
    reset = 1;
    tick();
    n_checks++;
    if (outs !== 10'b0) begin
      n_errors++;
      $display("FAIL idle_outs got %b want %b", outs, 10'b0);
    end
  endtask

  task automatic test_run();
    do_reset();
    start(1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({pc_en, if_id_en, id_ex_clk_en, ex_mem_en, mem_wb_en, running, if_id_flush, id_ex_stall} !== 8'b11111100) begin
        n_errors++;
        $display("FAIL run_enables cycle %0d got %b want 11111100", i,
                 {pc_en, if_id_en, id_ex_clk_en, ex_mem_en, mem_wb_en, running, if_id_flush, id_ex_stall});
      end
      tick();
    end
    n_checks++;
    if (cycle_cnt !== 32'd10) begin
      n_errors++;
      $display("FAIL run_cnt got %0d want 10", cycle_cnt);
    end
  endtask

  // Assumes RUN from test_run.
  task automatic test_load_use();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_rt = 3;
    #1;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_stall, id_ex_clk_en} !== 4'b0011) begin
      n_errors++;
      $display("FAIL lu_stall got %b want 0011", {pc_en, if_id_en, id_ex_stall, id_ex_clk_en});
    end
    id_rs = 1; id_rt = 5;
    #1;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_stall} !== 3'b001) begin
      n_errors++;
      $display("FAIL lu_rt_stall got %b want 001", {pc_en, if_id_en, id_ex_stall});
    end
    ex_rt = 0; id_rs = 0; id_rt = 0;
    #1;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_stall} !== 3'b110) begin
      n_errors++;
      $display("FAIL lu_zero_reg got %b want 110", {pc_en, if_id_en, id_ex_stall});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    id_branch_taken = 1;
    #1;
    n_checks++;
    if ({if_id_flush, pc_en, id_ex_stall} !== 3'b110) begin
      n_errors++;
      $display("FAIL br_flush got %b want 110", {if_id_flush, pc_en, id_ex_stall});
    end
    ex_mem_read = 1; ex_rt = 7; id_rt = 7;
    #1;
    n_checks++;
    if ({if_id_flush, id_ex_stall, pc_en} !== 3'b010) begin
      n_errors++;
      $display("FAIL br_lu_prio got %b want 010", {if_id_flush, id_ex_stall, pc_en});
    end
    clear_inputs();
    id_jump = 1;
    #1;
    n_checks++;
    if (if_id_flush !== 1'b1) begin
      n_errors++;
      $display("FAIL jump_flush got %b want 1", if_id_flush);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_step();
    int adv_seen;
    adv_seen = 0;
    do_reset();
    start(1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 5; w++) begin
        ex_mem_read = 1; ex_rt = 4; id_rs = 4; id_branch_taken = 1;
        #1;
        n_checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_clk_en, id_ex_stall, ex_mem_en, mem_wb_en, running} !== 8'b00000001) begin
          n_errors++;
          $display("FAIL step_wait pulse %0d got %b want 00000001", p,
                   {pc_en, if_id_en, if_id_flush, id_ex_clk_en, id_ex_stall, ex_mem_en, mem_wb_en, running});
        end
        adv_seen += int'(id_ex_clk_en);
        clear_inputs();
        tick();
      end
      dbg_step = 1;
      #1;
      adv_seen += int'(id_ex_clk_en);
      tick();
      dbg_step = 1;   // ignored while executing the step
      #1;
      n_checks++;
      if ({pc_en, id_ex_clk_en, mem_wb_en} !== 3'b111) begin
        n_errors++;
        $display("FAIL step_exec pulse %0d got %b want 111", p, {pc_en, id_ex_clk_en, mem_wb_en});
      end
      adv_seen += int'(id_ex_clk_en);
      tick();
      dbg_step = 0;
    end
    n_checks++;
    if (adv_seen !== 3) begin
      n_errors++;
      $display("FAIL step_windows got %0d want 3", adv_seen);
    end
    n_checks++;
    if (cycle_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL step_cnt got %0d want 3", cycle_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    start(1'b0);
    id_halt = 1;
    #1;
    n_checks++;
    if ({pc_en, if_id_flush} !== 2'b10) begin
      n_errors++;
      $display("FAIL halt_same_cycle got %b want 10", {pc_en, if_id_flush});
    end
    tick();
    id_halt = 0;
    for (int i = 0; i < 3; i++) begin
      wb_halt = (i == 2);
      #1;
      n_checks++;
      if ({pc_en, if_id_en, if_id_flush, id_ex_clk_en, mem_wb_en} !== 5'b01111) begin
        n_errors++;
        $display("FAIL halt_drain cycle %0d got %b want 01111", i,
                 {pc_en, if_id_en, if_id_flush, id_ex_clk_en, mem_wb_en});
      end
      tick();
    end
    wb_halt = 0;
    n_checks++;
    if (outs !== 10'b0000000001) begin
      n_errors++;
      $display("FAIL halted_outs got %b want 0000000001", outs);
    end
    n_checks++;
    if (cycle_cnt !== 32'd4) begin
      n_errors++;
      $display("FAIL halt_cnt got %0d want 4", cycle_cnt);
    end
    dbg_start = 1; dbg_step = 1;
    tick();
    tick();
    clear_inputs();
    n_checks++;
    if (outs !== 10'b0000000001 || cycle_cnt !== 32'd4) begin
      n_errors++;
      $display("FAIL halted_absorb got %b cnt %0d want 0000000001 cnt 4", outs, cycle_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start(1'b0);
    id_halt = 1;
    tick();
    id_halt = 0;
    tick();
    #2;
    reset = 0;
    #1;
    n_checks++;
    if (outs !== 10'b0 || cycle_cnt !== '0) begin
      n_errors++;
      $display("FAIL async_reset got %b cnt %0d want 0 cnt 0", outs, cycle_cnt);
    end
    @(negedge clk);
    reset = 1;
    tick();
    start(1'b0);
    #1;
    n_checks++;
    if ({pc_en, if_id_flush, running} !== 3'b101) begin
      n_errors++;
      $display("FAIL restart_fb_clear got %b want 101", {pc_en, if_id_flush, running});
    end
    tick();
  endtask

  // Randomized run against a model of the debug modes and halting rules.
  task automatic test_random();
    bit started, stepmode, exec_now, done, fb, adv, lu;
    logic [CNT_W-1:0] cnt;
    logic [9:0] exp;
    for (int run = 0; run < 4; run++) begin
      do_reset();
      started = 0; stepmode = 0; exec_now = 0; done = 0; fb = 0; cnt = '0;
      for (int c = 0; c < 250; c++) begin
        dbg_start       = (c == 2) || ($urandom_range(0, 31) == 0);
        dbg_step_mode   = run[0];
        dbg_step        = ($urandom_range(0, 3) == 0);
        id_rs           = REG_W'($urandom_range(0, 3));
        id_rt           = REG_W'($urandom_range(0, 3));
        ex_rt           = REG_W'($urandom_range(0, 3));
        ex_mem_read     = ($urandom_range(0, 2) == 0);
        id_branch_taken = ($urandom_range(0, 4) == 0);
        id_jump         = ($urandom_range(0, 6) == 0);
        id_halt         = ($urandom_range(0, 40) == 0);
        wb_halt         = ($urandom_range(0, 90) == 0);
        @(negedge clk);
        adv = started && !done && (!stepmode || exec_now);
        lu  = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        exp = {adv && !lu && !fb, adv && !lu,
               adv && !lu && (id_branch_taken || id_jump || fb),
               adv, adv && lu, 1'b0, adv, adv, started && !done, done};
        n_checks++;
        if (outs !== exp || cycle_cnt !== cnt) begin
          n_errors++;
          $display("FAIL random run %0d cycle %0d got %b cnt %0d want %b cnt %0d",
                   run, c, outs, cycle_cnt, exp, cnt);
        end
        @(posedge clk);
        if (!started) begin
          if (dbg_start) begin
            started = 1;
            stepmode = dbg_step_mode;
          end
        end else if (!done) begin
          if (wb_halt && adv) done = 1;
          if (stepmode) exec_now = exec_now ? 1'b0 : dbg_step;
        end
        if (id_halt && adv && !lu) fb = 1;
        if (adv) cnt = cnt + 1;
        #1;
      end
      clear_inputs();
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_step();
    test_halt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Generates per-stage enables, the IF/ID flush and the ID/EX bubble/flush controls from three sources: the debug run mode (continuous or single-step), load-use hazards and taken branches/jumps.
- Freezes fetch once a HALT is decoded, and declares the core halted when that HALT retires in WB.
- Counts executed (advanced) cycles for the debug unit.

Parameters:
- CNT_W, 32, width of the advanced-cycle counter.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- dbg_start  in  1  one-cycle pulse; leaves IDLE
- dbg_step_mode  in  1  1 = single-step, 0 = continuous; sampled on dbg_start
- dbg_step  in  1  one-cycle pulse; advances the pipeline one cycle in step mode
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- ex_rt  in  REG_W  rt of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- id_branch_taken  in  1  branch resolved taken in ID
- id_jump  in  1  J/JAL/JR/JALR in ID
- id_halt  in  1  HALT decoded in ID
- wb_halt  in  1  HALT in WB
- pc_en  out  1  PC write enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID clears to NOP
- id_ex_clk_en  out  1  ID/EX load enable
- id_ex_stall  out  1  ID/EX inserts bubble (load-use)
- id_ex_flush  out  1  ID/EX inserts NOP
- ex_mem_en  out  1  EX/MEM enable
- mem_wb_en  out  1  MEM/WB enable
- running  out  1  state is RUN or STEP_*
- halted  out  1  state is HALTED
- cycle_cnt  out  CNT_W  advanced cycles since leaving IDLE

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, fetch_block = 0, cycle_cnt = 0. All outputs are 0.
- States: IDLE, RUN, STEP_WAIT, STEP_EXEC, HALTED.
  - IDLE: dbg_start moves to RUN if dbg_step_mode = 0, otherwise to STEP_WAIT.
  - RUN: advance = 1 every cycle.
  - STEP_WAIT: advance = 0. dbg_step moves to STEP_EXEC.
  - STEP_EXEC: advance = 1 for exactly one cycle, then returns to STEP_WAIT. dbg_step pulses arriving in STEP_EXEC are ignored.
  - From RUN, STEP_WAIT or STEP_EXEC: wb_halt && advance moves to HALTED.
  - HALTED: absorbing until reset. dbg_start and dbg_step are ignored.
- Base enables, all combinational from the registered state:
  - id_ex_clk_en = ex_mem_en = mem_wb_en = advance.
  - pc_en = if_id_en = advance.
- Load-use hazard: lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt).
  - If lu && advance: pc_en = 0, if_id_en = 0, id_ex_stall = 1.
- Control hazard: if (id_branch_taken || id_jump) && advance && !lu: if_id_flush = 1. Load-use wins; the branch is re-evaluated the next cycle.
- HALT fetch block: on id_halt && advance && !lu, set fetch_block (sticky; cleared only by reset).
  - While fetch_block = 1: pc_en = 0, if_id_en = 1, if_id_flush = 1, so IF/ID holds NOPs.
  - Downstream stages keep advancing until the HALT reaches WB.
- Gating rule: id_ex_stall, id_ex_flush and if_id_flush are never asserted while advance = 0. ID/EX gives stall/flush priority over clk_en, so asserting them when frozen would corrupt a frozen stage.
- id_ex_flush is 0 in this revision; the port is reserved for exception flush.
- cycle_cnt increments by 1 on every advance cycle and wraps modulo 2^CNT_W. It holds in IDLE, STEP_WAIT and HALTED.
- Simultaneous events:
  - dbg_start in a non-IDLE state is ignored.
  - wb_halt and id_halt in the same cycle: HALTED wins.
  - Reset mid-step or mid-drain returns to IDLE with no residual fetch_block.
- Latency: all outputs except cycle_cnt are combinational from state plus hazard inputs. State and cycle_cnt update one cycle after the event that changes them.

Decomposition:
- Shared package pipeline_ctrl_pkg holds the state encoding enum (IDLE = 0, RUN = 1, STEP_WAIT = 2, STEP_EXEC = 3, HALTED = 4, 3 bits) and the NOP register index constant 0.
- One natural sub-module, hazard_detect: purely combinational, computes lu from id_rs, id_rt, ex_rt and ex_mem_read. It is reusable by the forwarding unit's tests.

Test Plan:
1. Reset, dbg_step_mode = 0, dbg_start; hold 10 cycles with no hazards -> running = 1; pc_en = if_id_en = id_ex_clk_en = 1 every cycle; cycle_cnt = 10.
2. In RUN: ex_mem_read = 1, ex_rt = 5, id_rs = 5 for one cycle -> pc_en = 0, if_id_en = 0, id_ex_stall = 1, id_ex_clk_en = 1. Repeat with ex_rt = 0 -> no stall.
3. In RUN: id_branch_taken = 1 -> if_id_flush = 1 that cycle. Same with lu = 1 -> if_id_flush = 0, id_ex_stall = 1.
4. Step mode: dbg_start with dbg_step_mode = 1, then three dbg_step pulses 5 cycles apart -> exactly three single-cycle advance windows, cycle_cnt = 3. Between pulses all enables 0; hazard inputs asserted there still give id_ex_stall = 0.
5. In RUN: pulse id_halt, then wb_halt 3 cycles later -> pc_en = 0 and if_id_flush = 1 from the cycle after id_halt; halted = 1 the cycle after wb_halt; all enables 0. A later dbg_start or dbg_step has no effect.
6. Drop reset to 0 asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately, cycle_cnt = 0. After release, dbg_start restarts cleanly with fetch_block clear.
